// File: rtl/ucsbece154_mem_pkg.sv
// Shared memory-side types and defaults for the SDRAM read-port arbiter
// and the icache/dcache block-fill logic.
package ucsbece154_mem_pkg;

   localparam int NUM_REQ     = 3;
   localparam int BLOCK_WORDS = 4;
   localparam int WORD_SIZE   = 32;

   localparam int REQ_IMISS    = 0;
   localparam int REQ_DMISS    = 1;
   localparam int REQ_PREFETCH = 2;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN,
      GAP
   } arb_state_t;

endpackage

// File: rtl/ucsbece154_arb_picker.sv
// Combinational winner select; search starts at rr_ptr and wraps.
// A zero pointer gives fixed priority, lowest index first.
module ucsbece154_arb_picker #(
   parameter int NUM_REQ = 3,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IW-1:0]      win_idx,
   output logic               win_any
);

   int idx;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      win_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!win_any && req_valid[idx]) begin
            win_any     = 1'b1;
            win_oh[idx] = 1'b1;
            win_idx     = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// SDRAM read-port arbiter: one BLOCK_WORDS burst per grant, with cancel.
// Define ARB_RR_EN for round-robin; otherwise fixed priority (req 0 first).
module ucsbece154_mem_arbiter #(
   parameter int NUM_REQ     = ucsbece154_mem_pkg::NUM_REQ,
   parameter int BLOCK_WORDS = ucsbece154_mem_pkg::BLOCK_WORDS,
   parameter int WORD_SIZE   = ucsbece154_mem_pkg::WORD_SIZE
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [NUM_REQ-1:0]    ReqValid,
   input  logic [NUM_REQ*32-1:0] ReqAddress,
   input  logic [NUM_REQ-1:0]    ReqCancel,
   output logic [NUM_REQ-1:0]    ReqGrant,
   output logic [NUM_REQ-1:0]    RespValid,
   output logic [WORD_SIZE-1:0]  RespData,
   output logic                  RespLast,
   output logic [31:0]           MemReadAddress,
   output logic                  MemReadRequest,
   input  logic [WORD_SIZE-1:0]  MemDataIn,
   input  logic                  MemDataReady
);
   import ucsbece154_mem_pkg::*;

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BLOCK_WORDS);
   localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

   arb_state_t         state;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] win_oh;
   logic               win_any;
   logic [CW-1:0]      cnt;
   logic               last_beat;
   logic               cancel;

   assign last_beat = (cnt == LAST);
   assign cancel    = (state == BURST) && ReqCancel[owner];

   ucsbece154_arb_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .req_valid (ReqValid),
      .rr_ptr    (rr_ptr),
      .win_oh    (win_oh),
      .win_idx   (win_idx),
      .win_any   (win_any)
   );

`ifdef ARB_RR_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_ptr <= '0;
      end else if (state == IDLE && win_any) begin
         rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end
`else
   assign rr_ptr = '0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= IDLE;
         owner          <= '0;
         cnt            <= '0;
         ReqGrant       <= '0;
         RespValid      <= '0;
         RespData       <= '0;
         RespLast       <= 1'b0;
         MemReadAddress <= '0;
         MemReadRequest <= 1'b0;
      end else begin
         ReqGrant  <= '0;
         RespValid <= '0;
         RespLast  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_any) begin
                  ReqGrant       <= win_oh;
                  MemReadAddress <= ReqAddress[32*win_idx +: 32];
                  MemReadRequest <= 1'b1;
                  owner          <= win_idx;
                  cnt            <= '0;
                  state          <= BURST;
               end
            end
            BURST, DRAIN: begin
               if (cancel) state <= DRAIN;
               if (MemDataReady) begin
                  cnt <= cnt + 1'b1;
                  // a beat coinciding with cancel is dropped
                  if (state == BURST && !cancel) begin
                     RespData         <= MemDataIn;
                     RespValid[owner] <= 1'b1;
                     RespLast         <= last_beat;
                  end
                  if (last_beat) begin
                     MemReadRequest <= 1'b0;
                     state          <= GAP;
                  end
               end
            end
            GAP: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
